// File: rtl/tl_pkg.sv
// Shared types and constants for the intersection scheduler.
package tl_pkg;

  // Controller states; AR is the all-red clearance between phases.
  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    EW_G = 3'd2,
    EW_Y = 3'd3,
    PED  = 3'd4,
    AR   = 3'd5
  } state_t;

  // Phase IDs double as bit positions in the pend vector {ped, ew, ns}.
  localparam logic [1:0] PH_NS  = 2'd0;
  localparam logic [1:0] PH_EW  = 2'd1;
  localparam logic [1:0] PH_PED = 2'd2;

  // Timing defaults, in ticks.
  localparam int G_MIN_DEF     = 3;
  localparam int Y_TIME_DEF    = 2;
  localparam int AR_TIME_DEF   = 1;
  localparam int WALK_TIME_DEF = 4;

  // State that serves a given phase.
  function automatic state_t phase_state(input logic [1:0] ph);
    case (ph)
      PH_NS:   return NS_G;
      PH_EW:   return EW_G;
      default: return PED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick counter for the current phase: clear, advance on tick, optional
// saturation at limit-1, and a "count == limit-1" flag.
module phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       sat,
  input  logic [3:0] limit,
  output logic       at_last
);

  logic [3:0] cnt;

  // limit is always 1..15, so limit-1 never underflows.
  assign at_last = (cnt == limit - 4'd1);

  // Counter register: clear has priority; saturating phases hold at limit-1,
  // other phases leave before reaching it, so the count never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 4'd0;
    end else if (en && !(sat && at_last)) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/intersection_sched.sv
// Two-road traffic light scheduler with a pedestrian phase, all-red
// clearance between phases and round-robin service of latched requests.
module intersection_sched
  import tl_pkg::*;
#(
  parameter int G_MIN     = G_MIN_DEF,
  parameter int Y_TIME    = Y_TIME_DEF,
  parameter int AR_TIME   = AR_TIME_DEF,
  parameter int WALK_TIME = WALK_TIME_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic       ns_g,
  output logic       ns_y,
  output logic       ns_r,
  output logic       ew_g,
  output logic       ew_y,
  output logic       ew_r,
  output logic       ped_walk,
  output logic [2:0] pend
);

  state_t     state, state_n;
  logic [1:0] last, last_n;
  logic [2:0] pend_n, req_m, clr_m;
  logic [3:0] limit;
  logic       at_last, changed, in_green;
  logic [1:0] pick, cand;
  logic       found;

  assign in_green = (state == NS_G) || (state == EW_G);
  assign changed  = (state_n != state);

  phase_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (tick),
    .clr     (changed),
    .sat     (in_green),
    .limit   (limit),
    .at_last (at_last)
  );

  // Duration limit for the current state.
  always_comb begin
    limit = 4'(AR_TIME);
    case (state)
      NS_G, EW_G: limit = 4'(G_MIN);
      NS_Y, EW_Y: limit = 4'(Y_TIME);
      PED:        limit = 4'(WALK_TIME);
      default:    limit = 4'(AR_TIME);
    endcase
  end

  // Round-robin pick: first pending phase after the last served one;
  // with nothing pending, fall back to the last vehicle green (NS after PED).
  always_comb begin
    pick  = (last == PH_PED) ? PH_NS : last;
    found = 1'b0;
    cand  = PH_NS;
    for (int i = 1; i <= 3; i++) begin
      cand = 2'((int'(last) + i) % 3);
      if (!found && pend[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state logic; transitions happen only on tick cycles.
  always_comb begin
    state_n = state;
    if (tick) begin
      case (state)
        NS_G: if (at_last && (pend[PH_EW] || pend[PH_PED])) state_n = NS_Y;
        EW_G: if (at_last && (pend[PH_NS] || pend[PH_PED])) state_n = EW_Y;
        NS_Y, EW_Y, PED: if (at_last) state_n = AR;
        AR:   if (at_last) state_n = phase_state(pick);
        default: state_n = NS_G;
      endcase
    end
  end

  // Request latching: requests for the phase being served are dropped,
  // and entering a phase clears its bit even against a same-cycle request.
  always_comb begin
    req_m = {ped_req & (state != PED), ew_req & (state != EW_G), ns_req & (state != NS_G)};
    clr_m  = 3'b000;
    last_n = last;
    if (changed) begin
      case (state_n)
        NS_G: begin clr_m[PH_NS]  = 1'b1; last_n = PH_NS;  end
        EW_G: begin clr_m[PH_EW]  = 1'b1; last_n = PH_EW;  end
        PED:  begin clr_m[PH_PED] = 1'b1; last_n = PH_PED; end
        default: ;
      endcase
    end
    pend_n = (pend | req_m) & ~clr_m;
  end

  // State, request and last-served registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NS_G;
      pend  <= 3'b000;
      last  <= PH_NS;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      last  <= last_n;
    end
  end

  // Moore lamp decode.
  always_comb begin
    {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, ped_walk} = 7'b0;
    case (state)
      NS_G:    begin ns_g = 1'b1; ew_r = 1'b1; end
      NS_Y:    begin ns_y = 1'b1; ew_r = 1'b1; end
      EW_G:    begin ew_g = 1'b1; ns_r = 1'b1; end
      EW_Y:    begin ew_y = 1'b1; ns_r = 1'b1; end
      PED:     begin ns_r = 1'b1; ew_r = 1'b1; ped_walk = 1'b1; end
      default: begin ns_r = 1'b1; ew_r = 1'b1; end
    endcase
  end

endmodule

// File: tb/tb_intersection_sched.sv
// Bench for intersection_sched: directed scenarios plus random traffic,
// checked cycle by cycle against a tick-level behavioural model.
module tb_intersection_sched;

  localparam int G_MIN = 3, Y_TIME = 2, AR_TIME = 1, WALK_TIME = 4;

  // Lamp vector order {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, ped_walk}
  localparam logic [6:0] L_NSG = 7'b1000010;
  localparam logic [6:0] L_NSY = 7'b0100010;
  localparam logic [6:0] L_EWG = 7'b0011000;
  localparam logic [6:0] L_EWY = 7'b0010100;
  localparam logic [6:0] L_PED = 7'b0010011;
  localparam logic [6:0] L_AR  = 7'b0010010;

  localparam int MS_NSG = 0, MS_NSY = 1, MS_EWG = 2, MS_EWY = 3, MS_PED = 4, MS_AR = 5;

  logic clk = 1'b0, rst = 1'b0, tick = 1'b0;
  logic ns_req = 1'b0, ew_req = 1'b0, ped_req = 1'b0;
  logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, ped_walk;
  logic [2:0] pend;
  wire  [6:0] lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, ped_walk};

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];

  // Model state: phase, ticks spent in it, latched requests, last served phase.
  int       m_st = MS_NSG;
  int       m_n = 0;
  bit [2:0] m_pend = 3'b000;
  int       m_last = 0;

  intersection_sched #(
    .G_MIN(G_MIN), .Y_TIME(Y_TIME), .AR_TIME(AR_TIME), .WALK_TIME(WALK_TIME)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .ns_req(ns_req), .ew_req(ew_req), .ped_req(ped_req),
    .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r),
    .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
    .ped_walk(ped_walk), .pend(pend)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_lamps(input int st);
    case (st)
      MS_NSG:  return L_NSG;
      MS_NSY:  return L_NSY;
      MS_EWG:  return L_EWG;
      MS_EWY:  return L_EWY;
      MS_PED:  return L_PED;
      default: return L_AR;
    endcase
  endfunction

  // Phases 0/1/2 = NS/EW/PED map to their serving states.
  function automatic int serve_state(input int ph);
    return (ph == 0) ? MS_NSG : (ph == 1) ? MS_EWG : MS_PED;
  endfunction

  function automatic int choose_next();
    for (int k = 1; k <= 3; k++) begin
      if (m_pend[(m_last + k) % 3]) return serve_state((m_last + k) % 3);
    end
    return (m_last == 2) ? MS_NSG : serve_state(m_last);
  endfunction

  // One clock edge of the reference behaviour.
  function automatic void model_step(input bit r, input bit t, input bit [2:0] req);
    bit [2:0] req_eff;
    int nxt;
    if (r) begin
      m_st = MS_NSG; m_n = 0; m_pend = 3'b000; m_last = 0;
      return;
    end
    req_eff = req;
    if (m_st == MS_NSG) req_eff[0] = 1'b0;
    if (m_st == MS_EWG) req_eff[1] = 1'b0;
    if (m_st == MS_PED) req_eff[2] = 1'b0;
    nxt = m_st;
    if (t) begin
      case (m_st)
        MS_NSG: if (m_n + 1 >= G_MIN && (m_pend[1] || m_pend[2])) nxt = MS_NSY;
        MS_EWG: if (m_n + 1 >= G_MIN && (m_pend[0] || m_pend[2])) nxt = MS_EWY;
        MS_NSY, MS_EWY: if (m_n + 1 == Y_TIME) nxt = MS_AR;
        MS_PED: if (m_n + 1 == WALK_TIME) nxt = MS_AR;
        default: if (m_n + 1 == AR_TIME) nxt = choose_next();
      endcase
    end
    m_pend = m_pend | req_eff;
    if (nxt != m_st) begin
      m_n = 0;
      if (nxt == MS_NSG) begin m_pend[0] = 1'b0; m_last = 0; end
      if (nxt == MS_EWG) begin m_pend[1] = 1'b0; m_last = 1; end
      if (nxt == MS_PED) begin m_pend[2] = 1'b0; m_last = 2; end
    end else if (t) begin
      m_n++;
    end
    m_st = nxt;
  endfunction

  // Drive one cycle, advance the model, then compare after the edge.
  task automatic step(input bit r, input bit t, input bit [2:0] req);
    logic [9:0] exp;
    rst = r; tick = t; ns_req = req[0]; ew_req = req[1]; ped_req = req[2];
    @(posedge clk);
    model_step(r, t, req);
    exp_q.push_back({model_lamps(m_st), m_pend});
    #1;
    exp = exp_q.pop_front();
    check("lamps", 32'(lamps), 32'(exp[9:3]));
    check("pend", 32'(pend), 32'(exp[2:0]));
    check("one_ns_lamp", $countones({ns_g, ns_y, ns_r}), 1);
    check("one_ew_lamp", $countones({ew_g, ew_y, ew_r}), 1);
    check("no_dual_green", 32'(ns_g & ew_g), 0);
  endtask

  task automatic tick_once(input bit [2:0] req);
    step(1'b0, 1'b1, req);
    step(1'b0, 1'b0, 3'b000);
  endtask

  logic [6:0] seq_a[6]  = '{L_NSG, L_NSG, L_NSY, L_NSY, L_AR, L_EWG};
  logic [6:0] seq_b[11] = '{L_EWG, L_EWG, L_EWY, L_EWY, L_AR, L_PED,
                            L_PED, L_PED, L_PED, L_AR, L_NSG};

  initial begin
    // Reset, including an edge where tick and requests are also high.
    step(1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b1, 3'b111);
    check("rst_lamps", 32'(lamps), 32'(L_NSG));
    check("rst_pend", 32'(pend), 0);

    // Idle: rests in NS green.
    for (int i = 0; i < 20; i++) tick_once(3'b000);
    check("idle_lamps", 32'(lamps), 32'(L_NSG));
    check("idle_pend", 32'(pend), 0);

    // EW request from a fresh NS green.
    step(1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b0, 3'b010);
    check("ew_latched", 32'(pend), 32'(3'b010));
    for (int i = 0; i < 6; i++) begin
      tick_once(3'b000);
      check("seq_ew", 32'(lamps), 32'(seq_a[i]));
    end
    check("ew_cleared", 32'(pend[1]), 0);

    // All requests during EW green; ped_req again on PED entry is absorbed.
    step(1'b0, 1'b0, 3'b111);
    check("all_latched", 32'(pend), 32'(3'b101));
    for (int i = 0; i < 11; i++) begin
      tick_once((i == 5) ? 3'b100 : 3'b000);
      check("seq_all", 32'(lamps), 32'(seq_b[i]));
      if (i == 5) check("ped_absorbed", 32'(pend[2]), 0);
    end
    check("all_served", 32'(pend), 0);
    for (int i = 0; i < 8; i++) tick_once(3'b000);
    check("no_second_walk", 32'(lamps), 32'(L_NSG));

    // Reset while in EW yellow.
    step(1'b0, 1'b0, 3'b010);
    for (int i = 0; i < 20 && m_st != MS_EWG; i++) tick_once(3'b000);
    step(1'b0, 1'b0, 3'b001);
    for (int i = 0; i < 20 && m_st != MS_EWY; i++) tick_once(3'b000);
    check("in_ew_yellow", 32'(lamps), 32'(L_EWY));
    step(1'b1, 1'b1, 3'b111);
    check("rst_yel_lamps", 32'(lamps), 32'(L_NSG));
    check("rst_yel_pend", 32'(pend), 0);
    // Counter restarted: a new EW request needs the full minimum green.
    step(1'b0, 1'b0, 3'b010);
    tick_once(3'b000);
    tick_once(3'b000);
    check("min_green_hold", 32'(lamps), 32'(L_NSG));
    tick_once(3'b000);
    check("min_green_yield", 32'(lamps), 32'(L_NSY));

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0,
           {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
